// File: rtl/adder_pkg.sv
// Types shared by adder_32 consumers: the adder width and the result record
// that travels downstream of the adder.
package adder_pkg;

    localparam int ADD_W = 32;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             cout;
        logic             overflow;
    } adder_result_t;

endpackage

// File: rtl/result_fifo.sv
// Generic DEPTH-entry synchronous FIFO of adder_result_t.
// A push while full and a pop while empty are ignored.
module result_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  adder_result_t din,
    output adder_result_t head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_fifo: DEPTH must be a power of two and at least 2");
    end

    adder_result_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed through a non-empty gate.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered valid/ready result stage behind adder_32 with a sticky overflow flag.
// Define ADDER_OVF_CNT_EN to add the saturating ovf_count output.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_overflow,
    input  logic             clr_sticky,
    output logic             sticky_ovf
`ifdef ADDER_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    if (WIDTH != ADD_W) begin : g_bad_width
        $error("adder_result_stage: WIDTH must equal ADD_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("adder_result_stage: CNT_W must be at least 1");
    end

    adder_result_t din;
    adder_result_t head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_push;

    assign din      = '{sum: sum, cout: cout, overflow: overflow};
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign ovf_push = push && overflow;

    result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (din),
        .head (head),
        .full (full),
        .empty(empty)
    );

    assign out_valid    = !empty;
    assign out_sum      = empty ? '0 : head.sum;
    assign out_cout     = empty ? 1'b0 : head.cout;
    assign out_overflow = empty ? 1'b0 : head.overflow;

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (rst)             sticky_ovf <= 1'b0;
        else if (ovf_push)   sticky_ovf <= 1'b1;
        else if (clr_sticky) sticky_ovf <= 1'b0;
    end

`ifdef ADDER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                               ovf_count <= '0;
        else if (clr_sticky)                   ovf_count <= ovf_push ? CNT_W'(1) : '0;
        else if (ovf_push && ovf_count != '1)  ovf_count <= ovf_count + 1'b1;
    end
`endif

endmodule

// File: doc/adder_result_stage.md
# adder_result_stage

- Registered, flow-controlled result stage directly downstream of `adder_32`.
- Captures each `{sum, cout, overflow}` result into a small FIFO and presents it to the consumer under a valid/ready handshake.
- Tracks a sticky overflow flag across results.
- Decouples the combinational adder from back-pressure in the consuming pipeline stage.

## Interface

Parameters:
- `WIDTH`, 32: data width; must match `adder_32` (32).
- `DEPTH`, 2: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: overflow-event counter width (used only with `ADDER_OVF_CNT_EN`).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — `sum`/`cout`/`overflow` carry a result this cycle.
- `in_ready`  out  1  — stage can accept; equals `!full`, forced 0 while `rst` = 1.
- `sum`  in  WIDTH  — adder sum.
- `cout`  in  1  — adder carry-out.
- `overflow`  in  1  — adder signed overflow.
- `out_valid`  out  1  — FIFO not empty.
- `out_ready`  in  1  — consumer takes the head entry.
- `out_sum`  out  WIDTH  — head entry sum; 0 when empty.
- `out_cout`  out  1  — head entry carry; 0 when empty.
- `out_overflow`  out  1  — head entry overflow; 0 when empty.
- `clr_sticky`  in  1  — clear the sticky flag and the counter.
- `sticky_ovf`  out  1  — set when any accepted result had `overflow` = 1.
- `ovf_count`  out  CNT_W  — accepted-overflow count; present only with `ADDER_OVF_CNT_EN`.

## Operation

- **Push:** when `in_valid && in_ready`, write `{sum, cout, overflow}` at the write pointer.
- **Pop:** when `out_valid && out_ready`, advance the read pointer.
- **Occupancy:** `count` is log2(DEPTH)+1 bits wide.
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- **Pointers:** log2(DEPTH) bits, wrapping modulo DEPTH.
- **Full:** `in_ready` = 0, no pass-through; an `in_valid` held while full is not lost, the producer simply waits.
- **Full with pop in the same cycle:** the push is still refused (`in_ready` was 0); the entry frees for the next cycle.
- **Empty with push in the same cycle:** `out_valid` stays 0 this cycle; no combinational bypass.
- **Pop while empty:** ignored; pointers and count are unchanged.
- **Sticky flag:** set on any accepted entry with `overflow` = 1; cleared by `clr_sticky`.
  - If set and clear occur in the same cycle, set wins (`sticky_ovf` = 1 next cycle).
- **Data values:** stored bit-exact; no arithmetic is performed on them.

## Timing

- **Reset:** while `rst` = 1, all of the following are 0 and remain 0 in the cycle `rst` deasserts, except `in_ready`, which is 1 in that cycle:
  - `in_ready`, `out_valid`, `out_sum`, `out_cout`, `out_overflow`, `sticky_ovf`, `ovf_count`
  - pointers, count
- **Reset mid-operation:** all stored entries are discarded; no pop is reported.
- **Latency:** 1 cycle. An entry accepted at edge N is visible on `out_*` with `out_valid` = 1 after edge N.
- **Throughput:** one push and one pop per cycle sustained while 0 < count < DEPTH.
- **Outputs:** `out_*` are driven from registered state. `in_ready` is decoded from registered count (no combinational path from `out_ready`).

## Configuration

- **`ADDER_OVF_CNT_EN` defined:** `ovf_count` port exists.
  - Increments by 1 on each accepted entry with `overflow` = 1.
  - Saturates at 2^CNT_W − 1.
  - Cleared by `clr_sticky`; with a simultaneous increment, the result is 1.
  - Reset value 0.
- **Not defined:** the port and counter are absent. The sticky flag is unaffected.

## Structure

- **Shared package `adder_pkg`:**
  - `ADD_W` = 32.
  - Typedef `adder_result_t` = `{sum[ADD_W-1:0], cout, overflow}`.
  - Shared by `adder_32` consumers and this stage.
- **Sub-module `result_fifo`:** generic DEPTH-entry synchronous FIFO of `adder_result_t` with push/pop/full/empty.
- **Top level:** this block instantiates `result_fifo` and adds the handshake gating, zeroing of `out_*` when empty, the sticky flag and the optional counter.

## Test plan

- Reset held 3 cycles with `in_valid` = 1 → all outputs 0 and `in_ready` = 0 during reset; `in_ready` = 1 in the first cycle after release.
- Push `sum`=0x00000056, `cout`=0, `overflow`=0 with `out_ready` = 1 → next cycle `out_valid` = 1, `out_sum` = 0x00000056; the following cycle `out_valid` = 0, `out_sum` = 0.
- `out_ready` = 0, push 0xFFFFFFFF/`cout`=1/`overflow`=0, then 0x80000000/`cout`=0/`overflow`=1 → `in_ready` = 0, and a third result is held off. Raise `out_ready` → results drain in order 0xFFFFFFFF then 0x80000000.
- Full FIFO with `out_ready` = 1 and `in_valid` = 1 → no push that cycle; push accepted the next cycle; pointers wrap and order is preserved over 10 transfers.
- Accept 0x80000000 with `overflow` = 1 while `clr_sticky` = 1 → `sticky_ovf` = 1 (and `ovf_count` = 1 with the macro). `clr_sticky` alone → both 0.
- With `ADDER_OVF_CNT_EN`, `CNT_W` = 2, five overflow results → `ovf_count` reads 1, 2, 3, 3, 3.
